// File: rtl/apb_color_sampler_if.sv
// rtl/apb_color_sampler_if.sv - APB bus bundle for the colour sampler
interface apb_color_sampler_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_color_sampler.sv
// rtl/apb_color_sampler.sv - APB colour-sensor front end with timed channel scan and sample FIFO
module apb_color_sampler #(
  parameter int NUM_CH     = 5,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  apb_color_sampler_if.slave apb,
  output logic               irq
);

  localparam int         PTR_W   = $clog2(FIFO_DEPTH);
  localparam int         LVL_W   = PTR_W + 1;
  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] A_PERIOD = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] A_SEED   = ADDR_WIDTH'(8'h08);
  localparam logic [ADDR_WIDTH-1:0] A_THRESH = ADDR_WIDTH'(8'h0C);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(8'h10);
  localparam logic [ADDR_WIDTH-1:0] A_DATA   = ADDR_WIDTH'(8'h14);
  localparam logic [ADDR_WIDTH-1:0] A_IRQEN  = ADDR_WIDTH'(8'h18);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  typedef struct packed {
    logic [2:0]  ch;
    logic [15:0] sample;
  } entry_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // An all-zero LFSR would lock up, so zero seeds are substituted.
  function automatic logic [15:0] seed_fix(input logic [15:0] s);
    return (s == 16'h0000) ? 16'hACE1 : s;
  endfunction

  // Registers
  logic              en;
  logic [NUM_CH-1:0] ctrl_mask;
  logic [15:0]       period;
  logic [15:0]       seed;
  logic [7:0]        thresh;
  logic [1:0]        irq_en;
  logic              ovf;
  logic              missed;

  // Bus decode
  logic access, err, wr_ok, rd_ok, addr_hit;
  logic sel_ctrl, sel_period, sel_seed, sel_thresh, sel_status, sel_data, sel_irqen;
  logic wr_ctrl, wr_period, wr_seed, wr_thresh, wr_status, wr_irqen;
  logic clr_fifo;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        unused_pwdata;

  // Timer / scan
  logic [15:0] cnt;
  logic        tick;
  state_t      state, state_nxt;
  logic [2:0]  ch, ch_nxt;
  logic        scan_act;
  logic        missed_set;
  logic [7:0]  mask8;
  logic        adv;

  // LFSRs
  logic [15:0] lfsr     [NUM_CH];
  logic [15:0] lfsr_nxt [NUM_CH];
  logic [15:0] push_sample;

  // FIFO
  entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level;
  logic               empty, full;
  logic               push, pop, ovf_set;
  entry_t             head;

  assign wdata         = apb.pwdata[31:0];
  assign unused_pwdata = ^apb.pwdata;

  assign access      = apb.psel & apb.penable;
  assign apb.pready  = access;
  assign apb.pslverr = err;

  // Address decode; misaligned addresses match no entry and so report an error.
  always_comb begin
    sel_ctrl   = 1'b0;
    sel_period = 1'b0;
    sel_seed   = 1'b0;
    sel_thresh = 1'b0;
    sel_status = 1'b0;
    sel_data   = 1'b0;
    sel_irqen  = 1'b0;
    addr_hit   = 1'b1;
    case (apb.paddr)
      A_CTRL:   sel_ctrl   = 1'b1;
      A_PERIOD: sel_period = 1'b1;
      A_SEED:   sel_seed   = 1'b1;
      A_THRESH: sel_thresh = 1'b1;
      A_STATUS: sel_status = 1'b1;
      A_DATA:   sel_data   = 1'b1;
      A_IRQEN:  sel_irqen  = 1'b1;
      default:  addr_hit   = 1'b0;
    endcase
  end

  assign err   = access & (~addr_hit | (apb.pwrite & sel_data));
  assign wr_ok = access & apb.pwrite & ~err;
  assign rd_ok = access & ~apb.pwrite & ~err;

  assign wr_ctrl   = wr_ok & sel_ctrl;
  assign wr_period = wr_ok & sel_period;
  assign wr_seed   = wr_ok & sel_seed;
  assign wr_thresh = wr_ok & sel_thresh;
  assign wr_status = wr_ok & sel_status;
  assign wr_irqen  = wr_ok & sel_irqen;
  assign clr_fifo  = wr_ctrl & wdata[1];

  // Software-visible configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      en        <= 1'b0;
      ctrl_mask <= '0;
      period    <= 16'h0000;
      seed      <= 16'h0001;
      thresh    <= 8'h00;
      irq_en    <= 2'b00;
    end else begin
      if (wr_ctrl) begin
        en        <= wdata[0];
        ctrl_mask <= wdata[8 +: NUM_CH];
      end
      if (wr_period) period <= wdata[15:0];
      if (wr_seed)   seed   <= wdata[15:0];
      if (wr_thresh) thresh <= wdata[7:0];
      if (wr_irqen)  irq_en <= wdata[1:0];
    end
  end

  assign tick = en & (period != 16'h0000) & (cnt == period - 16'd1);

  // Sample period counter; restarts whenever disabled or reprogrammed.
  always_ff @(posedge clk) begin
    if (rst || !en || wr_period) begin
      cnt <= 16'h0000;
    end else if (period != 16'h0000) begin
      cnt <= tick ? 16'h0000 : cnt + 16'd1;
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ch    <= 3'd0;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;
    end
  end

  // Scan FSM: one channel per cycle, fixed NUM_CH-cycle scan, abort on disable.
  always_comb begin
    state_nxt  = state;
    ch_nxt     = ch;
    scan_act   = 1'b0;
    missed_set = 1'b0;
    case (state)
      S_IDLE: begin
        if (tick) begin
          state_nxt = S_SCAN;
          ch_nxt    = 3'd0;
        end
      end
      S_SCAN: begin
        if (!en) begin
          state_nxt = S_IDLE;
          ch_nxt    = 3'd0;
        end else begin
          scan_act   = 1'b1;
          missed_set = tick;
          if (ch == LAST_CH) begin
            state_nxt = S_IDLE;
            ch_nxt    = 3'd0;
          end else begin
            ch_nxt = ch + 3'd1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        ch_nxt    = 3'd0;
      end
    endcase
  end

  assign mask8 = 8'(ctrl_mask);
  assign adv   = scan_act & mask8[ch];

  // Next LFSR value per channel and the one selected by the scan index.
  always_comb begin
    push_sample = 16'h0000;
    for (int i = 0; i < NUM_CH; i++) begin
      lfsr_nxt[i] = lfsr_step(lfsr[i]);
      if (ch == 3'(i)) push_sample = lfsr_nxt[i];
    end
  end

  // Sensor-model LFSRs: reseed on SEED write, otherwise step when scanned.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        lfsr[i] <= seed_fix(16'h0001 ^ 16'(i));
      end else if (wr_seed) begin
        lfsr[i] <= seed_fix(wdata[15:0] ^ 16'(i));
      end else if (adv && ch == 3'(i)) begin
        lfsr[i] <= lfsr_nxt[i];
      end
    end
  end

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(FIFO_DEPTH));
  assign head    = mem[rd_ptr];
  assign push    = adv & ~full & ~clr_fifo;
  assign ovf_set = adv & full & ~clr_fifo;
  assign pop     = rd_ok & sel_data & ~empty;

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{ch: ch, sample: push_sample};
  end

  // FIFO pointers and fill level.
  always_ff @(posedge clk) begin
    if (rst || clr_fifo) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky error flags; a hardware set beats a simultaneous W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf    <= 1'b0;
      missed <= 1'b0;
    end else begin
      ovf    <= ovf_set    | (ovf    & ~(wr_status & wdata[2]));
      missed <= missed_set | (missed & ~(wr_status & wdata[3]));
    end
  end

  // Registered interrupt from fill level and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= (irq_en[0] & (thresh != 8'h00) & (8'(level) >= thresh))
           | (irq_en[1] & (ovf | missed));
    end
  end

  // Read mux; prdata stays zero outside a successful read access.
  always_comb begin
    rdata = 32'h0;
    if (rd_ok) begin
      if (sel_ctrl) begin
        rdata[0]           = en;
        rdata[8 +: NUM_CH] = ctrl_mask;
      end
      if (sel_period) rdata[15:0] = period;
      if (sel_seed)   rdata[15:0] = seed;
      if (sel_thresh) rdata[7:0]  = thresh;
      if (sel_status) begin
        rdata[0]    = empty;
        rdata[1]    = full;
        rdata[2]    = ovf;
        rdata[3]    = missed;
        rdata[15:8] = 8'(level);
      end
      if (sel_data && !empty) begin
        rdata[31]    = 1'b1;
        rdata[18:16] = head.ch;
        rdata[15:0]  = head.sample;
      end
      if (sel_irqen) rdata[1:0] = irq_en;
    end
  end

  assign apb.prdata = DATA_WIDTH'(rdata);

endmodule
